// File: rtl/match_sched_pkg.sv
// rtl/match_sched_pkg.sv - state encoding and constants shared by the match_scheduler slice
package match_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ARM,
    LAUNCH,
    WAIT,
    REPORT,
    SEEK,
    FINISH
  } match_sched_state;

  localparam int NULL_CHAR = 0;

endpackage

// File: rtl/match_watchdog.sv
// rtl/match_watchdog.sv - clear/enable cycle counter flagging expiry at TIMEOUT_CYCLES-1
module match_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count;

  // Holds at the limit so a stalled caller never sees the flag drop by wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/match_scheduler.sv
// rtl/match_scheduler.sv - runs the matcher over each zero-terminated word and streams one result per word
// Optional per-word found bitmap is built when MATCH_SCHED_BITMAP_EN is defined.
module match_scheduler
  import match_sched_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int CNT_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   input_base_addr,
  input  logic [ADDR_WIDTH-1:0]   input_end_addr,
  output logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [DATA_WIDTH-1:0]   mem_data_i,
  input  logic [ADDR_WIDTH-1:0]   m_addr_i,
  output logic [ADDR_WIDTH-1:0]   m_input_start_addr,
  output logic                    m_cs,
  output logic                    m_rst_n,
  input  logic                    m_found,
  input  logic                    m_done,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [CNT_WIDTH-1:0]    res_word_idx,
  output logic                    res_found,
  output logic                    res_timeout,
  output logic [CNT_WIDTH-1:0]    match_count,
  output logic                    busy,
  output logic                    done,
  output logic [2**CNT_WIDTH-1:0] found_bitmap
);

  match_sched_state state, state_d;

  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] ptr_next;
  logic [CNT_WIDTH-1:0]  word_idx;
  logic                  is_null;
  logic                  expired;
  logic                  handshake;

  assign ptr_next  = ptr + 1'b1;
  assign is_null   = (mem_data_i == DATA_WIDTH'(NULL_CHAR));
  assign handshake = (state == REPORT) && res_ready;

  match_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == ARM),
    .enable (state == WAIT),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    mem_addr_i = ptr;
    case (state)
      IDLE:   if (start) state_d = CHECK;
      CHECK: begin
        if ((ptr == input_end_addr) || is_null) state_d = FINISH;
        else                                    state_d = ARM;
      end
      ARM: begin
        mem_addr_i = m_addr_i;
        state_d    = LAUNCH;
      end
      LAUNCH: begin
        mem_addr_i = m_addr_i;
        state_d    = WAIT;
      end
      WAIT: begin
        mem_addr_i = m_addr_i;
        if (m_done || expired) state_d = REPORT;
      end
      REPORT: if (res_ready) state_d = SEEK;
      SEEK: begin
        if (is_null)                          state_d = CHECK;
        else if (ptr_next == input_end_addr)  state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath; m_rst_n is registered from the next state so it is a clean one-cycle low in ARM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr                <= '0;
      word_idx           <= '0;
      match_count        <= '0;
      m_input_start_addr <= '0;
      m_rst_n            <= 1'b0;
      res_found          <= 1'b0;
      res_timeout        <= 1'b0;
    end else begin
      m_rst_n <= (state_d != ARM);
      case (state)
        IDLE: begin
          if (start) begin
            ptr         <= input_base_addr;
            word_idx    <= '0;
            match_count <= '0;
          end
        end
        CHECK: if (state_d == ARM) m_input_start_addr <= ptr;
        ARM: begin
          res_found   <= 1'b0;
          res_timeout <= 1'b0;
        end
        WAIT: begin
          if (m_done)       res_found   <= m_found;
          else if (expired) res_timeout <= 1'b1;
        end
        REPORT: begin
          if (res_ready && res_found && (match_count != {CNT_WIDTH{1'b1}}))
            match_count <= match_count + 1'b1;
        end
        SEEK: begin
          if (is_null) begin
            ptr      <= ptr_next;
            word_idx <= word_idx + 1'b1;
          end else if (ptr_next != input_end_addr) begin
            ptr <= ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MATCH_SCHED_BITMAP_EN
  logic [2**CNT_WIDTH-1:0] bitmap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap_q <= '0;
    end else if ((state == IDLE) && start) begin
      bitmap_q <= '0;
    end else if (handshake) begin
      bitmap_q[word_idx] <= res_found;
    end
  end

  assign found_bitmap = bitmap_q;
`else
  assign found_bitmap = '0;
`endif

  assign res_valid    = (state == REPORT);
  assign res_word_idx = word_idx;
  assign m_cs         = (state == LAUNCH);
  assign busy         = (state != IDLE);
  assign done         = (state == FINISH);

endmodule

// File: tb/tb_match_scheduler.sv
// tb/tb_match_scheduler.sv - table-driven bench for match_scheduler with a behavioural matcher
module tb_match_scheduler;

  localparam int BUDGET = 600;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  input_base_addr;
  logic [3:0]  input_end_addr;
  logic [3:0]  mem_addr_i;
  logic [7:0]  mem_data_i;
  logic [3:0]  m_addr_i;
  logic [3:0]  m_input_start_addr;
  logic        m_cs;
  logic        m_rst_n;
  logic        m_found;
  logic        m_done;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_word_idx;
  logic        res_found;
  logic        res_timeout;
  logic [3:0]  match_count;
  logic        busy;
  logic        done;
  logic [15:0] found_bitmap;

  match_scheduler dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .input_base_addr   (input_base_addr),
    .input_end_addr    (input_end_addr),
    .mem_addr_i        (mem_addr_i),
    .mem_data_i        (mem_data_i),
    .m_addr_i          (m_addr_i),
    .m_input_start_addr(m_input_start_addr),
    .m_cs              (m_cs),
    .m_rst_n           (m_rst_n),
    .m_found           (m_found),
    .m_done            (m_done),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_word_idx      (res_word_idx),
    .res_found         (res_found),
    .res_timeout       (res_timeout),
    .match_count       (match_count),
    .busy              (busy),
    .done              (done),
    .found_bitmap      (found_bitmap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image and vocabulary word, byte i at bits [8*i +: 8].
  logic [127:0] cur_img = '0;
  logic [127:0] cur_voc = '0;
  logic         hang    = 1'b0;

  assign mem_data_i = cur_img[8*mem_addr_i +: 8];

  // Matcher model: walks from its start address comparing against cur_voc; done is held until re-armed.
  logic [3:0] mm_addr  = '0;
  int         mm_idx   = 0;
  logic       mm_run   = 1'b0;
  logic       mm_done  = 1'b0;
  logic       mm_found = 1'b0;

  always @(posedge clk) begin
    if (!m_rst_n) begin
      mm_run   <= 1'b0;
      mm_done  <= 1'b0;
      mm_found <= 1'b0;
    end else if (m_cs) begin
      mm_run  <= 1'b1;
      mm_addr <= m_input_start_addr;
      mm_idx  <= 0;
    end else if (mm_run && !hang) begin
      if (mm_idx >= 15 || mem_data_i != cur_voc[8*mm_idx +: 8]) begin
        mm_run <= 1'b0; mm_done <= 1'b1; mm_found <= 1'b0;
      end else if (mem_data_i == 8'd0) begin
        mm_run <= 1'b0; mm_done <= 1'b1; mm_found <= 1'b1;
      end else begin
        mm_addr <= mm_addr + 1'b1;
        mm_idx  <= mm_idx + 1;
      end
    end
  end

  assign m_addr_i = mm_addr;
  assign m_done   = mm_done;
  assign m_found  = mm_found;

  typedef struct {
    string        name;
    logic [127:0] image;
    logic [127:0] vocab;
    logic [3:0]   base;
    logic [3:0]   end_a;
    bit           hang;
    int           stall;
    int           n_res;
    logic [3:0]   exp_found;
    logic [3:0]   exp_to;
    logic [3:0]   exp_count;
    logic [15:0]  exp_bitmap;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [127:0] put(input logic [127:0] img, input int a, input string s);
    logic [127:0] r;
    r = img;
    for (int i = 0; i < s.len(); i++) r[8*((a + i) % 16) +: 8] = s[i];
    return r;
  endfunction

  function automatic vec_t mk(input string nm, input logic [127:0] img, input logic [127:0] voc,
                              input logic [3:0] b, input logic [3:0] e, input bit h, input int st,
                              input int n, input logic [3:0] f, input logic [3:0] t,
                              input logic [3:0] c, input logic [15:0] bm);
    vec_t v;
    v.name = nm; v.image = img; v.vocab = voc; v.base = b; v.end_a = e; v.hang = h;
    v.stall = st; v.n_res = n; v.exp_found = f; v.exp_to = t; v.exp_count = c; v.exp_bitmap = bm;
    return v;
  endfunction

  task automatic run_pass(input vec_t v);
    int         nres, narm, ncs, ndone, hold, cs_cyc, cyc;
    logic       prev_valid;
    logic [3:0] c_idx;
    logic       c_found, c_to;
    logic [15:0] exp_bm;
    nres = 0; narm = 0; ncs = 0; ndone = 0; hold = 0; cs_cyc = 0; cyc = 0;
    prev_valid = 1'b0; c_idx = '0; c_found = 1'b0; c_to = 1'b0;
    cur_img = v.image; cur_voc = v.vocab; hang = v.hang;
    res_ready = 1'b1;
    @(negedge clk);
    input_base_addr = v.base;
    input_end_addr  = v.end_a;
    start = 1'b1;
    while (cyc < BUDGET && ndone == 0) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (!m_rst_n) narm++;
      if (m_cs) begin ncs++; cs_cyc = cyc; end
      if (res_valid && !prev_valid) begin
        c_idx = res_word_idx; c_found = res_found; c_to = res_timeout;
        chk($sformatf("%s word_idx[%0d]", v.name, nres), c_idx, nres);
        if (nres < 4) begin
          chk($sformatf("%s found[%0d]", v.name, nres), c_found, v.exp_found[nres]);
          chk($sformatf("%s timeout[%0d]", v.name, nres), c_to, v.exp_to[nres]);
        end
        // LAUNCH cycle followed by 64 WAIT cycles before REPORT
        if (v.hang) chk($sformatf("%s timeout latency", v.name), cyc - cs_cyc, 65);
        nres++;
        if (nres == 1 && v.stall > 0) begin
          hold = v.stall;
          res_ready = 1'b0;
        end
      end else if (res_valid) begin
        chk($sformatf("%s payload held", v.name), {res_word_idx, res_found, res_timeout},
            {c_idx, c_found, c_to});
        chk($sformatf("%s no rearm while held", v.name), m_rst_n, 1'b1);
        hold--;
        if (hold <= 0) res_ready = 1'b1;
      end
      prev_valid = res_valid;
      if (done) ndone++;
    end
    res_ready = 1'b1;
    chk($sformatf("%s done seen", v.name), ndone, 1);
    if (v.n_res == 0) chk($sformatf("%s done latency", v.name), cyc, 2);
    chk($sformatf("%s result count", v.name), nres, v.n_res);
    chk($sformatf("%s arm count", v.name), narm, v.n_res);
    chk($sformatf("%s cs count", v.name), ncs, v.n_res);
    @(negedge clk);
    chk($sformatf("%s done one cycle", v.name), done, 1'b0);
    chk($sformatf("%s idle after", v.name), busy, 1'b0);
    chk($sformatf("%s match_count", v.name), match_count, v.exp_count);
`ifdef MATCH_SCHED_BITMAP_EN
    exp_bm = v.exp_bitmap;
`else
    exp_bm = 16'h0000;
`endif
    chk($sformatf("%s found_bitmap", v.name), found_bitmap, exp_bm);
  endtask

  vec_t vecs[8];

  initial begin
    logic [127:0] img_cd;
    int w;
    img_cd = put(put(128'h0, 0, "cat"), 4, "dog");
    vecs[0] = mk("cat_dog",  img_cd, put(128'h0, 0, "cat"), 4'd0, 4'd9, 1'b0, 0, 2,
                 4'b0001, 4'b0000, 4'd1, 16'h0001);
    vecs[1] = mk("stall",    img_cd, put(128'h0, 0, "cat"), 4'd0, 4'd9, 1'b0, 5, 2,
                 4'b0001, 4'b0000, 4'd1, 16'h0001);
    vecs[2] = mk("dog_only", img_cd, put(128'h0, 0, "dog"), 4'd0, 4'd9, 1'b0, 0, 2,
                 4'b0010, 4'b0000, 4'd1, 16'h0002);
    vecs[3] = mk("timeout",  img_cd, put(128'h0, 0, "cat"), 4'd0, 4'd9, 1'b1, 0, 2,
                 4'b0000, 4'b0011, 4'd0, 16'h0000);
    vecs[4] = mk("empty",    img_cd, put(128'h0, 0, "cat"), 4'd5, 4'd5, 1'b0, 0, 0,
                 4'b0000, 4'b0000, 4'd0, 16'h0000);
    vecs[5] = mk("wrap",     put(128'h0, 14, "ab"), put(128'h0, 0, "ab"), 4'd14, 4'd2, 1'b0, 0, 1,
                 4'b0001, 4'b0000, 4'd1, 16'h0001);
    vecs[6] = mk("three",    put(put(put(128'h0, 0, "a"), 2, "a"), 4, "b"), put(128'h0, 0, "a"),
                 4'd0, 4'd6, 1'b0, 0, 3, 4'b0011, 4'b0000, 4'd2, 16'h0003);
    vecs[7] = mk("unterm",   put(128'h0, 0, "abcx"), put(128'h0, 0, "abc"), 4'd0, 4'd3, 1'b0, 0, 1,
                 4'b0000, 4'b0000, 4'd0, 16'h0000);

    rst_n = 1'b0; start = 1'b0; res_ready = 1'b1;
    input_base_addr = '0; input_end_addr = '0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {res_valid, busy, done, m_cs, m_rst_n, res_found, res_timeout,
                          res_word_idx, match_count, mem_addr_i, m_input_start_addr}, 0);
    chk("reset bitmap", found_bitmap, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_pass(vecs[i]);

    // Asynchronous reset while the matcher is hung in WAIT, then a clean pass from word 0.
    cur_img = img_cd; cur_voc = put(128'h0, 0, "cat"); hang = 1'b1;
    input_base_addr = 4'd0; input_end_addr = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!m_cs && w < 20) begin @(negedge clk); w++; end
    chk("reached LAUNCH", m_cs, 1'b1);
    repeat (10) @(negedge clk);
    chk("busy in WAIT", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outputs", {res_valid, busy, done, m_cs, m_rst_n, res_found, res_timeout,
                                res_word_idx, match_count, mem_addr_i, m_input_start_addr}, 0);
    chk("async reset bitmap", found_bitmap, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    run_pass(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/match_scheduler.md
Name: match_scheduler

Overview:
- Sequences the `matcher` block over a buffer of zero-terminated words held in input memory.
- Each word is submitted to the matcher in turn; the matcher is re-armed between words by pulsing its local reset.
- One found/not-found result per word is streamed out over a valid/ready handshake.
- The block also owns the single input-memory read port, muxing it between its own word scan and the matcher's `addr_i`.

Parameters:
- ADDR_WIDTH, 4, input-memory address width.
- DATA_WIDTH, 8, character width.
- CNT_WIDTH, 4, width of word index and match counter.
- TIMEOUT_CYCLES, 64, watchdog limit per word (>=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a pass; sampled in IDLE only
- input_base_addr  in  ADDR_WIDTH  first character of first word
- input_end_addr  in  ADDR_WIDTH  exclusive end of buffer
- mem_addr_i  out  ADDR_WIDTH  input-memory address (memory reads combinationally)
- mem_data_i  in  DATA_WIDTH  input-memory data
- m_addr_i  in  ADDR_WIDTH  matcher's input address
- m_input_start_addr  out  ADDR_WIDTH  start address presented to the matcher
- m_cs  out  1  matcher chip select
- m_rst_n  out  1  matcher local reset, active low
- m_found  in  1  matcher found
- m_done  in  1  matcher done
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_word_idx  out  CNT_WIDTH  index of the reported word
- res_found  out  1  word present in vocabulary
- res_timeout  out  1  watchdog expired, no matcher decision
- match_count  out  CNT_WIDTH  found words this pass, saturating
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of pass
- found_bitmap  out  2**CNT_WIDTH  per-word found bits (see Optional Feature)

Behaviour:
- Reset values:
  - All outputs 0; `m_rst_n`=0.
  - Internal `ptr`, word index and timer are 0; state is IDLE.
  - Reset is honoured mid-pass: the block returns to IDLE and pending results are discarded.
- States: IDLE, CHECK, ARM, LAUNCH, WAIT, REPORT, SEEK, FINISH.
- IDLE:
  - On `start`: `ptr`<=`input_base_addr`, word_idx<=0, `match_count`<=0, bitmap<=0; go to CHECK.
  - `start` is ignored outside IDLE.
- CHECK:
  - `mem_addr_i`=`ptr`.
  - If `ptr`==`input_end_addr` or `mem_data_i`==0, go to FINISH (empty word ends the list).
  - Otherwise `m_input_start_addr`<=`ptr`; go to ARM.
- ARM: `m_rst_n` low for exactly this one cycle (registered output, glitch-free); timer<=0; go to LAUNCH.
- LAUNCH: `m_cs`=1 for exactly one cycle; go to WAIT.
- WAIT:
  - `mem_addr_i`=`m_addr_i`; timer increments.
  - If `m_done`: capture `m_found`; go to REPORT.
  - Else if timer==TIMEOUT_CYCLES-1 (this covers the matcher ERR state, which never raises `done`): `res_timeout`=1, `res_found`=0; go to REPORT.
  - `m_done` wins if both occur in the same cycle.
- REPORT:
  - `res_valid`=1; `res_word_idx`/`res_found`/`res_timeout` are held stable until `res_ready`.
  - On handshake: if found, `match_count`++ (saturates at all-ones). Go to SEEK.
- SEEK:
  - `mem_addr_i`=`ptr`.
  - If `mem_data_i`==0: `ptr`<=`ptr`+1, word_idx++; go to CHECK.
  - Else if `ptr`+1==`input_end_addr`: go to FINISH.
  - Else `ptr`<=`ptr`+1.
- FINISH: `done`=1 for one cycle; go to IDLE. `match_count` is held until the next `start`.
- Address and index arithmetic:
  - `ptr` wraps modulo 2**ADDR_WIDTH; `input_end_addr`==`input_base_addr` yields an immediate FINISH with no results.
  - word_idx wraps; results continue to be reported after a wrap.
- `mem_addr_i` mux: matcher owns the port in ARM/LAUNCH/WAIT; the scheduler owns it in every other state.
- `m_cs` is 0 everywhere except LAUNCH. The matcher is always re-armed through ARM before each word.

Optional Feature:
- Macro: MATCH_SCHED_BITMAP_EN.
- Defined: on each REPORT handshake, `found_bitmap[word_idx]`<=`res_found`; the bitmap is cleared on `start` and held after FINISH.
- Undefined: `found_bitmap` is tied to 0 and no bitmap flops are synthesised.

Decomposition:
- Package `match_sched_pkg` holds:
  - the state enum `match_sched_state`;
  - `NULL_CHAR` = 0.
- Sub-module `match_watchdog`: a clear/enable counter with an `expired` output at TIMEOUT_CYCLES-1.

Test Plan:
1. Memory: 0:"c" 1:"a" 2:"t" 3:0 4:"d" 5:"o" 6:"g" 7:0 8:0, end=9; vocab holds "cat" only; `res_ready`=1 → results (0,found=1), (1,found=0); `match_count`=1; one `done` pulse; `m_rst_n` low exactly twice.
2. Same buffer, `res_ready` low for 5 cycles at the first result → `res_valid` and payload held stable, no second ARM until handshake.
3. Matcher model held in a never-done state → `res_timeout`=1 exactly 64 cycles after LAUNCH, then scan continues to the next word.
4. `input_end_addr`==`input_base_addr`=5, `start` → `done` 2 cycles later, no `res_valid`, `m_cs` never asserted.
5. Async `rst_n` asserted during WAIT → all outputs 0 and `m_rst_n`=0 immediately; new `start` after release runs a clean pass from word 0.
6. Base=14, end=2, buffer "ab",0 at 14..15,0 → `ptr` wraps 15→0, one result, FINISH at address 0; MATCH_SCHED_BITMAP_EN build shows `found_bitmap`=…0001 when "ab" is in the vocabulary.
